oled_spi_writer: RTL and testbench
==================================

OLED_SPI_WRITER -- requirements
Module: oled_spi_writer

Interface
REQ-001 SHALL have clk_1m  input  1  system clock (1 MHz); all logic on its rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have spi_write_start  input  1  request; held high by the upstream sequencer until it sees spi_write_done.
REQ-004 SHALL have spi_data  input  10  [9:8] type (00 command, 01 display data, 1x no-op); [7:0] byte.
REQ-005 SHALL have spi_write_done  output  1  one-cycle completion pulse.
REQ-006 SHALL have oled_cs_n  output  1  panel chip select, active-low.
REQ-007 SHALL have oled_dc  output  1  panel D/C# (0 command, 1 data).
REQ-008 SHALL have oled_sclk  output  1  SPI clock, mode 0 (idle low, sampled on rising edge).
REQ-009 SHALL have oled_mosi  output  1  SPI data, MSB first.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, LOAD, SHIFT, DONE, GAP; all outputs registered.
REQ-012 IDLE: on sampling spi_write_start=1 at edge T, SHALL latch spi_data into an internal 10-bit register and go to LOAD (type 0x) or DONE (type 1x).
REQ-013 LOAD (after T): oled_cs_n=0, oled_dc=latched[8], oled_mosi=latched[7], oled_sclk=0.
REQ-014 SHIFT: one phase per cycle, 16 phases; odd phases drive sclk=1 with mosi stable; even phases drive sclk=0 and advance mosi to the next lower bit; bit counter 3-bit, wraps 7->0 only at transfer end.
REQ-015 After edge T+16 SHALL have emitted exactly 8 sclk high pulses with sclk back at 0.
REQ-016 DONE (after T+17 for a transfer): oled_cs_n=1, spi_write_done=1 for exactly one cycle, oled_mosi=0.
REQ-017 No-op type 1x: no cs/sclk activity; spi_write_done pulses after T+1.
REQ-018 GAP (one cycle after DONE): spi_write_done=0; spi_write_start SHALL be ignored in DONE and GAP so the still-high request of the finished transfer is never re-accepted; return to IDLE.
REQ-019 Minimum request-to-request spacing: next start sampled no earlier than 3 edges after the done pulse edge.
REQ-020 spi_data and spi_write_start changes after T SHALL NOT affect the transfer in progress; early deassertion of start SHALL NOT abort, done still pulses.
REQ-021 oled_dc SHALL hold its last value between transfers.

Reset
REQ-022 rst_n low SHALL force IDLE immediately, including mid-transfer: oled_cs_n=1, oled_sclk=0, oled_mosi=0, oled_dc=0, spi_write_done=0, busy=0, latch=10'h000, counters 0.
REQ-023 After reset release, first request SHALL be accepted on the first rising edge sampling start=1.

Configuration
REQ-024 Macro OLED_SPI_SLOW_SCLK_EN: when defined, each SHIFT phase SHALL last 2 cycles (sclk = clk_1m/4), done after T+33 for a transfer.
REQ-025 Without OLED_SPI_SLOW_SCLK_EN: one cycle per phase (sclk = clk_1m/2), done after T+17; port list identical in both builds.

Verification
REQ-026 Command 10'h0AE, start held until done -> cs_n low 17 cycles, dc=0, MOSI bits 1,0,1,0,1,1,1,0 on 8 sclk rises, done after T+17, single transfer only.
REQ-027 Data 10'h1FF then 10'h100 back-to-back via upstream handshake -> dc=1, MOSI all-ones then all-zeros, two done pulses, no third transfer.
REQ-028 No-op 10'h300 -> no cs_n/sclk toggles, done after T+1.
REQ-029 rst_n low at T+9 of 10'h0B0 -> cs_n=1, sclk=0, done never pulses; new 10'h010 after release transfers correctly.
REQ-030 spi_data changed to 10'h1AA at T+5 of 10'h155 transfer -> MOSI still 0,1,0,1,0,1,0,1, dc=1.
REQ-031 OLED_SPI_SLOW_SCLK_EN build, 10'h081 -> sclk high 2 cycles per bit, done after T+33.

Source files
------------

// File: rtl/oled_spi_writer_if.sv
// oled_spi_writer_if: request/completion handshake between the upstream sequencer and the OLED SPI writer.
interface oled_spi_writer_if;
   logic       spi_write_start;
   logic [9:0] spi_data;
   logic       spi_write_done;
   logic       busy;
   modport master (output spi_write_start, spi_data, input spi_write_done, busy);
   modport slave (input spi_write_start, spi_data, output spi_write_done, busy);
endinterface

// File: rtl/oled_spi_writer.sv
// oled_spi_writer: serialises one command/data byte to an SPI OLED panel (mode 0, MSB first).
// Define OLED_SPI_SLOW_SCLK_EN to stretch every SCLK phase to two clk_1m cycles.
module oled_spi_writer (
   input  logic             clk_1m,
   input  logic             rst_n,
   oled_spi_writer_if.slave bus,
   output logic             oled_cs_n,
   output logic             oled_dc,
   output logic             oled_sclk,
   output logic             oled_mosi
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;
   logic [2:0] state, nxt, bit_cnt, nb;
   logic [9:0] lat;
   logic [7:0] tx_byte;
   logic [4:0] ph, nph;
   logic       tick;
   assign nph     = ph + 5'd1;
   assign nb      = bit_cnt + 3'd1;
   assign tx_byte = lat[7:0];
`ifdef OLED_SPI_SLOW_SCLK_EN
   logic div;
   assign tick = div;
   always_ff @(posedge clk_1m or negedge rst_n)
      if (!rst_n) div <= 1'b0;
      else        div <= (state == SHIFT) ? ~div : 1'b0;
`else
   assign tick = 1'b1;
`endif
   // a no-op enters DONE with done low and raises it one cycle later
   always_comb
      nxt = (state == IDLE)  ? (bus.spi_write_start ? (bus.spi_data[9] ? DONE : LOAD) : IDLE) :
            (state == LOAD)  ? SHIFT :
            (state == SHIFT) ? ((tick && ph == 5'd16) ? DONE : SHIFT) :
            (state == DONE)  ? (bus.spi_write_done ? GAP : DONE) :
                               IDLE;
   always_ff @(posedge clk_1m or negedge rst_n)
      if (!rst_n) begin
         state              <= IDLE;
         lat                <= 10'h000;
         ph                 <= 5'd0;
         bit_cnt            <= 3'd0;
         oled_cs_n          <= 1'b1;
         oled_dc            <= 1'b0;
         oled_sclk          <= 1'b0;
         oled_mosi          <= 1'b0;
         bus.spi_write_done <= 1'b0;
         bus.busy           <= 1'b0;
      end else begin
         state    <= nxt;
         bus.busy <= nxt != IDLE;
         case (state)
            IDLE: if (bus.spi_write_start) begin
               lat <= bus.spi_data;
               if (!bus.spi_data[9]) begin
                  oled_cs_n <= 1'b0;
                  oled_dc   <= bus.spi_data[8];
                  oled_mosi <= bus.spi_data[7];
               end
            end
            LOAD: begin
               oled_dc   <= lat[8];
               oled_sclk <= 1'b1;
               ph        <= 5'd1;
            end
            SHIFT: if (tick) begin
               if (ph == 5'd16) begin
                  oled_cs_n          <= 1'b1;
                  oled_mosi          <= 1'b0;
                  bus.spi_write_done <= 1'b1;
                  ph                 <= 5'd0;
               end else begin
                  ph        <= nph;
                  oled_sclk <= nph[0];
                  if (!nph[0]) begin
                     bit_cnt   <= nb;
                     oled_mosi <= tx_byte[~nb];
                  end
               end
            end
            DONE: bus.spi_write_done <= lat[9] & ~bus.spi_write_done;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_oled_spi_writer.sv
// tb_oled_spi_writer: directed checks of the OLED SPI writer timing, framing, no-op and reset behaviour.
`timescale 1ns/1ps
module tb_oled_spi_writer;
`ifdef OLED_SPI_SLOW_SCLK_EN
   localparam int DN = 33, HI = 16;
`else
   localparam int DN = 17, HI = 8;
`endif
   logic clk_1m = 1'b0, rst_n = 1'b0;
   logic oled_cs_n, oled_dc, oled_sclk, oled_mosi;
   int total = 0, fails = 0;
   int cs_low, rises, high_cyc, dones, done_at, cs_edges;
   logic [7:0] rx;
   logic dc_s, busy0, busy_end, prev_sclk, prev_cs;
   oled_spi_writer_if bus ();
   oled_spi_writer dut (.clk_1m(clk_1m), .rst_n(rst_n), .bus(bus), .oled_cs_n(oled_cs_n),
                        .oled_dc(oled_dc), .oled_sclk(oled_sclk), .oled_mosi(oled_mosi));
   always #500 clk_1m = ~clk_1m;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // drive one request and record what the panel sees over the following 40 edges
   task automatic run(input logic [9:0] d, input int drop_at, input logic [9:0] alt, input int alt_at);
      bus.spi_data = d;
      bus.spi_write_start = 1'b1;
      cs_low = 0; rises = 0; high_cyc = 0; dones = 0; done_at = -1; cs_edges = 0; rx = 8'h00;
      prev_sclk = oled_sclk; prev_cs = oled_cs_n; dc_s = 1'bx; busy0 = 1'bx;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk_1m);
         @(negedge clk_1m);
         if (c == 0) busy0 = bus.busy;
         if (c == 5) dc_s = oled_dc;
         if (!oled_cs_n) cs_low++;
         if (oled_cs_n != prev_cs) cs_edges++;
         if (oled_sclk) high_cyc++;
         if (oled_sclk && !prev_sclk) begin
            rises++;
            rx = {rx[6:0], oled_mosi};
         end
         prev_sclk = oled_sclk;
         prev_cs = oled_cs_n;
         if (bus.spi_write_done) begin
            dones++;
            if (done_at < 0) done_at = c;
         end
         if (c == alt_at) bus.spi_data = alt;
         if (c == drop_at || (done_at >= 0 && c == done_at + 2)) bus.spi_write_start = 1'b0;
      end
      busy_end = bus.busy;
   endtask
   initial begin
      bus.spi_write_start = 1'b0;
      bus.spi_data = 10'h000;
      repeat (2) @(negedge clk_1m);
      chk("rst_cs_n", oled_cs_n, 1);
      chk("rst_sclk", oled_sclk, 0);
      chk("rst_mosi", oled_mosi, 0);
      chk("rst_dc", oled_dc, 0);
      chk("rst_done", bus.spi_write_done, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      run(10'h0AE, -1, 10'h000, -1);
      chk("cmd_busy0", busy0, 1);
      chk("cmd_cs_low", cs_low, DN);
      chk("cmd_dc", dc_s, 0);
      chk("cmd_rises", rises, 8);
      chk("cmd_high", high_cyc, HI);
      chk("cmd_bits", rx, 8'hAE);
      chk("cmd_done_at", done_at, DN);
      chk("cmd_dones", dones, 1);
      chk("cmd_busy_end", busy_end, 0);
      chk("cmd_sclk_idle", oled_sclk, 0);
      run(10'h1FF, -1, 10'h000, -1);
      chk("d1_dc", dc_s, 1);
      chk("d1_bits", rx, 8'hFF);
      chk("d1_dones", dones, 1);
      run(10'h100, -1, 10'h000, -1);
      chk("d2_dc", dc_s, 1);
      chk("d2_bits", rx, 8'h00);
      chk("d2_rises", rises, 8);
      chk("d2_dones", dones, 1);
      run(10'h300, -1, 10'h000, -1);
      chk("nop_done_at", done_at, 1);
      chk("nop_dones", dones, 1);
      chk("nop_cs_edges", cs_edges, 0);
      chk("nop_rises", rises, 0);
      chk("nop_busy0", busy0, 1);
      chk("nop_dc_hold", oled_dc, 1);
      run(10'h155, -1, 10'h1AA, 5);
      chk("chg_bits", rx, 8'h55);
      chk("chg_dc", dc_s, 1);
      chk("chg_dones", dones, 1);
      run(10'h03C, 3, 10'h000, -1);
      chk("early_done_at", done_at, DN);
      chk("early_bits", rx, 8'h3C);
      bus.spi_data = 10'h0B0;
      bus.spi_write_start = 1'b1;
      repeat (9) @(posedge clk_1m);
      @(negedge clk_1m);
      rst_n = 1'b0;
      bus.spi_write_start = 1'b0;
      #1;
      chk("mid_rst_cs_n", oled_cs_n, 1);
      chk("mid_rst_sclk", oled_sclk, 0);
      chk("mid_rst_mosi", oled_mosi, 0);
      chk("mid_rst_busy", bus.busy, 0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_1m);
         if (bus.spi_write_done) dones++;
         if (c == 3) rst_n = 1'b1;
      end
      chk("mid_rst_no_done", dones, 0);
      run(10'h010, -1, 10'h000, -1);
      chk("post_rst_bits", rx, 8'h10);
      chk("post_rst_dc", dc_s, 0);
      chk("post_rst_done_at", done_at, DN);
      chk("post_rst_dones", dones, 1);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
